// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with the IF/ID pipeline register.
// Keeps the PC, talks to a variable-latency instruction memory and hands
// {PC+4, instruction, valid} to decode. Handles hazard freeze (with a one-entry
// skid buffer for an instruction that returns while decode is frozen) and
// taken-branch redirects, including draining a wrong-path request in flight.
module fetch_stage #(
    parameter int ADDR_LEN  = 32,
    parameter int INSTR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [ADDR_LEN-1:0]  branch_addr,
    output logic                 imem_req,
    output logic [ADDR_LEN-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic [ADDR_LEN-1:0]  if_id_pc,
    output logic [INSTR_LEN-1:0] if_id_instr,
    output logic                 if_id_valid
);

    // FETCH : request outstanding, response is on the correct path
    // KILL  : request outstanding, response is wrong-path and gets dropped
    // STALL : no request, a good instruction waits in the skid buffer
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_KILL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [ADDR_LEN-1:0]  PC_STEP    = {{(ADDR_LEN-3){1'b0}}, 3'b100};
    localparam logic [ADDR_LEN-1:0]  ADDR_ZERO  = {ADDR_LEN{1'b0}};
    localparam logic [INSTR_LEN-1:0] INSTR_NOP  = {INSTR_LEN{1'b0}};

    // Sequential state
    state_t                 state_r;
    logic [ADDR_LEN-1:0]    pc_r;
    logic [ADDR_LEN-1:0]    tgt_r;
    logic [ADDR_LEN-1:0]    buf_pc_r;
    logic [INSTR_LEN-1:0]   buf_instr_r;
    logic [ADDR_LEN-1:0]    if_id_pc_r;
    logic [INSTR_LEN-1:0]   if_id_instr_r;
    logic                   if_id_valid_r;

    // Next-state values
    state_t                 state_s;
    logic [ADDR_LEN-1:0]    pc_s;
    logic [ADDR_LEN-1:0]    tgt_s;
    logic [ADDR_LEN-1:0]    buf_pc_s;
    logic [INSTR_LEN-1:0]   buf_instr_s;
    logic [ADDR_LEN-1:0]    if_id_pc_s;
    logic [INSTR_LEN-1:0]   if_id_instr_s;
    logic                   if_id_valid_s;

    // Sequential PC increment; wraps naturally modulo 2^ADDR_LEN.
    logic [ADDR_LEN-1:0]    pc_plus4_s;

    // Increment of the address currently being fetched
    always_comb begin
        pc_plus4_s = pc_r + PC_STEP;
    end

    // Memory request: never during reset, never while parked in STALL.
    // The address is the PC register itself, so it cannot move while a
    // request is open because pc only updates on the ack cycle.
    always_comb begin
        if (!rst) begin
            imem_req = 1'b0;
        end else if (state_r == ST_STALL) begin
            imem_req = 1'b0;
        end else begin
            imem_req = 1'b1;
        end
        imem_addr = pc_r;
    end

    // Next-state, PC, skid buffer and IF/ID update.
    // Priority each cycle: branch redirect, then freeze, then normal flow.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        tgt_s         = tgt_r;
        buf_pc_s      = buf_pc_r;
        buf_instr_s   = buf_instr_r;
        if_id_pc_s    = if_id_pc_r;
        if_id_instr_s = if_id_instr_r;
        if_id_valid_s = if_id_valid_r;

        case (state_r)
            ST_FETCH: begin
                if (branch_taken) begin
                    // Flush decode; pc field is left alone on a bubble
                    if_id_instr_s = INSTR_NOP;
                    if_id_valid_s = 1'b0;
                    if (imem_ack) begin
                        // The returning word is wrong-path; redirect now
                        pc_s    = branch_addr;
                        state_s = ST_FETCH;
                    end else begin
                        // Request still open: remember target, drain it
                        tgt_s   = branch_addr;
                        state_s = ST_KILL;
                    end
                end else if (imem_ack) begin
                    pc_s = pc_plus4_s;
                    if (freeze) begin
                        // Decode is frozen: park the word in the buffer
                        buf_pc_s    = pc_plus4_s;
                        buf_instr_s = imem_rdata;
                        state_s     = ST_STALL;
                    end else begin
                        if_id_pc_s    = pc_plus4_s;
                        if_id_instr_s = imem_rdata;
                        if_id_valid_s = 1'b1;
                        state_s       = ST_FETCH;
                    end
                end else begin
                    if (freeze) begin
                        // Hold IF/ID as it is
                        if_id_valid_s = if_id_valid_r;
                    end else begin
                        if_id_instr_s = INSTR_NOP;
                        if_id_valid_s = 1'b0;
                    end
                end
            end

            ST_KILL: begin
                if (branch_taken) begin
                    // Newest redirect wins over the pending one
                    tgt_s = branch_addr;
                end else begin
                    tgt_s = tgt_r;
                end

                if (branch_taken || !freeze) begin
                    if_id_instr_s = INSTR_NOP;
                    if_id_valid_s = 1'b0;
                end else begin
                    if_id_valid_s = if_id_valid_r;
                end

                if (imem_ack) begin
                    // Wrong-path data is dropped; restart at the target
                    if (branch_taken) begin
                        pc_s = branch_addr;
                    end else begin
                        pc_s = tgt_r;
                    end
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_KILL;
                end
            end

            ST_STALL: begin
                // imem_ack here is a protocol error and is not looked at
                if (branch_taken) begin
                    buf_pc_s      = ADDR_ZERO;
                    buf_instr_s   = INSTR_NOP;
                    if_id_instr_s = INSTR_NOP;
                    if_id_valid_s = 1'b0;
                    pc_s          = branch_addr;
                    state_s       = ST_FETCH;
                end else if (!freeze) begin
                    if_id_pc_s    = buf_pc_r;
                    if_id_instr_s = buf_instr_r;
                    if_id_valid_s = 1'b1;
                    state_s       = ST_FETCH;
                end else begin
                    state_s = ST_STALL;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean fetch
                if_id_instr_s = INSTR_NOP;
                if_id_valid_s = 1'b0;
                state_s       = ST_FETCH;
            end
        endcase
    end

    // State, PC, target, skid buffer and IF/ID registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= ADDR_ZERO;
            tgt_r         <= ADDR_ZERO;
            buf_pc_r      <= ADDR_ZERO;
            buf_instr_r   <= INSTR_NOP;
            if_id_pc_r    <= ADDR_ZERO;
            if_id_instr_r <= INSTR_NOP;
            if_id_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            tgt_r         <= tgt_s;
            buf_pc_r      <= buf_pc_s;
            buf_instr_r   <= buf_instr_s;
            if_id_pc_r    <= if_id_pc_s;
            if_id_instr_r <= if_id_instr_s;
            if_id_valid_r <= if_id_valid_s;
        end
    end

    // Drive the IF/ID outputs straight from their registers
    always_comb begin
        if_id_pc    = if_id_pc_r;
        if_id_instr = if_id_instr_r;
        if_id_valid = if_id_valid_r;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: hand-computed expected values for
// streaming, slow memory, freeze/skid, branch drain, branch in STALL,
// PC wrap and asynchronous reset mid-request.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int check_cnt;
    int error_cnt;

    fetch_stage #(.ADDR_LEN(32), .INSTR_LEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt = check_cnt + 1;
        if (obs !== exp) begin
            error_cnt = error_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the whole IF/ID triple
    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic v);
        check_value({tag, ".pc"}, {32'd0, if_id_pc}, {32'd0, pc});
        check_value({tag, ".instr"}, {32'd0, if_id_instr}, {32'd0, instr});
        check_value({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, v});
    endtask

    // Compare the memory request side
    task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
        check_value({tag, ".req"}, {63'd0, imem_req}, {63'd0, req});
        check_value({tag, ".addr"}, {32'd0, imem_addr}, {32'd0, addr});
    endtask

    initial begin
        check_cnt    = 0;
        error_cnt    = 0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;

        // Reset state
        step();
        step();
        check_ifid("reset", 32'd0, 32'd0, 1'b0);
        check_mem("reset", 1'b0, 32'd0);

        // Release away from the edge; request rises right after release
        rst = 1'b1;
        #1;
        check_mem("rel", 1'b1, 32'd0);

        // Zero-wait streaming 0x11, 0x22, 0x33
        imem_ack   = 1'b1;
        imem_rdata = 32'h11;
        step();
        check_ifid("s1", 32'd4, 32'h11, 1'b1);
        check_mem("s1", 1'b1, 32'd4);
        imem_rdata = 32'h22;
        step();
        check_ifid("s2", 32'd8, 32'h22, 1'b1);
        check_mem("s2", 1'b1, 32'd8);
        imem_rdata = 32'h33;
        step();
        check_ifid("s3", 32'd12, 32'h33, 1'b1);
        check_mem("s3", 1'b1, 32'd12);

        // Slow memory: three cycles without ack at address 12
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("wait", 32'd12, 32'd0, 1'b0);
            check_mem("wait", 1'b1, 32'd12);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hAA;
        step();
        check_ifid("slow", 32'd16, 32'hAA, 1'b1);
        check_mem("slow", 1'b1, 32'd16);

        // Freeze for two cycles, ack lands in the first
        freeze     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBB;
        step();
        check_ifid("frz1", 32'd16, 32'hAA, 1'b1);
        check_mem("frz1", 1'b0, 32'd20);
        imem_ack   = 1'b0;
        step();
        check_ifid("frz2", 32'd16, 32'hAA, 1'b1);
        check_mem("frz2", 1'b0, 32'd20);
        freeze = 1'b0;
        step();
        check_ifid("unfrz", 32'd20, 32'hBB, 1'b1);
        check_mem("unfrz", 1'b1, 32'd20);

        // Branch with request at 20 outstanding, ack two cycles later
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        check_ifid("br_kill", 32'd20, 32'd0, 1'b0);
        check_mem("br_kill", 1'b1, 32'd20);
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        step();
        check_ifid("br_wait", 32'd20, 32'd0, 1'b0);
        check_mem("br_wait", 1'b1, 32'd20);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD;
        step();
        check_ifid("br_drain", 32'd20, 32'd0, 1'b0);
        check_mem("br_drain", 1'b1, 32'h100);
        imem_rdata = 32'hCC;
        step();
        check_ifid("br_tgt", 32'h104, 32'hCC, 1'b1);
        check_mem("br_tgt", 1'b1, 32'h104);

        // Enter STALL, then branch and freeze together
        freeze     = 1'b1;
        imem_rdata = 32'hEE;
        step();
        check_mem("st_in", 1'b0, 32'h108);
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        imem_ack     = 1'b0;
        step();
        check_ifid("st_br", 32'h104, 32'd0, 1'b0);
        check_mem("st_br", 1'b1, 32'h200);
        branch_taken = 1'b0;
        freeze       = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 32'h77;
        step();
        check_ifid("st_tgt", 32'h204, 32'h77, 1'b1);

        // Branch with zero-wait ack to the top of the address space
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        imem_rdata   = 32'h5555;
        step();
        check_ifid("wr_br", 32'h204, 32'd0, 1'b0);
        check_mem("wr_br", 1'b1, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        imem_rdata   = 32'h99;
        step();
        check_ifid("wrap", 32'd0, 32'h99, 1'b1);
        check_mem("wrap", 1'b1, 32'd0);

        // Open a request at 0, then reset asynchronously mid-cycle
        imem_ack = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        check_ifid("arst", 32'd0, 32'd0, 1'b0);
        check_mem("arst", 1'b0, 32'd0);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h55;
        #1;
        check_mem("restart", 1'b1, 32'd0);
        step();
        check_ifid("restart", 32'd4, 32'h55, 1'b1);
        check_mem("restart2", 1'b1, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with integrated IF/ID pipeline register for the 6-stage MIPS pipeline. Holds the PC, issues requests to a variable-latency instruction memory, and delivers {PC+4, instruction, valid} to the ID stage. It is the direct consumer of `hazard_detected`, used here as `freeze`. It also consumes the taken-branch redirect from EXE, flushes wrong-path instructions, and buffers a returning instruction while ID is frozen.

## Interface
- `ADDR_LEN`, 32, PC / memory address width.
- `INSTR_LEN`, 32, instruction width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `freeze`  in  1  hazard stall from the hazard detection unit; hold IF/ID contents.
- `branch_taken`  in  1  redirect request from EXE, one cycle per branch.
- `branch_addr`  in  ADDR_LEN  redirect target, used as-is.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  ADDR_LEN  request address; always equals the `pc` register.
- `imem_ack`  in  1  memory response valid; may arrive in the same cycle as `imem_req` (zero-wait).
- `imem_rdata`  in  INSTR_LEN  instruction data; meaningful only when `imem_ack`=1.
- `if_id_pc`  out  ADDR_LEN  registered PC+4 of the delivered instruction.
- `if_id_instr`  out  INSTR_LEN  registered instruction; 0 (NOP) when not valid.
- `if_id_valid`  out  1  registered valid flag.

## Operation
- Registers:
  - `pc` holds the address being fetched.
  - `tgt` holds a pending branch target.
  - Skid buffer `{buf_pc, buf_instr}`.
  - 2-bit `state`.
- States:
  - FETCH: `imem_req`=1.
  - KILL: `imem_req`=1. An outstanding request is wrong-path and must be drained.
  - STALL: `imem_req`=0. A good instruction sits in the buffer.
- Memory rule:
  - Once `imem_req` is raised, `imem_addr` stays constant until the `imem_ack` cycle.
  - `pc` changes only on an ack cycle or outside FETCH/KILL.
- Priority per cycle is `branch_taken` > `freeze` > normal.
- FETCH, `branch_taken`=1:
  - IF/ID flushed: valid=0, instr=0, pc field unchanged.
  - If `imem_ack`=1 this cycle: data discarded, `pc`<=`branch_addr`, stay FETCH.
  - Else: `tgt`<=`branch_addr`, go to KILL.
- FETCH, ack=1, `freeze`=0:
  - IF/ID <= {pc+4, `imem_rdata`, 1}.
  - `pc`<=pc+4; stay FETCH.
- FETCH, ack=1, `freeze`=1:
  - IF/ID holds.
  - Buffer <= {pc+4, `imem_rdata`}; `pc`<=pc+4; go to STALL.
- FETCH, ack=0, `freeze`=0:
  - IF/ID <= bubble: valid=0, instr=0, pc field unchanged.
- FETCH, ack=0, `freeze`=1: IF/ID holds.
- KILL:
  - `branch_taken`=1 overwrites `tgt`.
  - IF/ID gets a bubble if `freeze`=0 or `branch_taken`=1, else holds.
  - On ack: data discarded, `pc`<=`tgt` (or `branch_addr` if a branch arrives in the same cycle), go to FETCH.
- STALL:
  - `branch_taken`=1: buffer discarded, IF/ID flushed, `pc`<=`branch_addr`, go to FETCH.
  - Else `freeze`=0: IF/ID <= {buf_pc, buf_instr, 1}, go to FETCH.
  - Else: hold.
- Arithmetic: pc+4 is modulo 2^ADDR_LEN, so 0xFFFFFFFC wraps to 0x00000000.
- `imem_ack` while `imem_req`=0 (STALL) is a protocol error and is ignored.

## Timing
- Reset (`rst`=0, asynchronous):
  - `pc`=0, `tgt`=0, buffer=0, state=FETCH.
  - `if_id_pc`=0, `if_id_instr`=0, `if_id_valid`=0.
  - `imem_req` is forced to 0 while `rst`=0 and rises in the first cycle after release.
- Reset asserted mid-request abandons the request; the memory must drop any pending ack when reset.
- Latency: ack in cycle N gives a valid IF/ID output in cycle N+1.
- Throughput: one instruction per cycle with zero-wait memory and no freeze.
- Redirect: `branch_taken` in cycle N puts the target on `imem_addr` in N+1 (FETCH or STALL case). In the KILL case it appears one cycle after the draining ack.
- Freeze release: with `freeze` low in cycle N, the buffered instruction is valid at IF/ID in N+1, and a new request issues in N+1.

## Test plan
- Reset, then ack in every cycle, rdata = 0x11, 0x22, 0x33: `imem_addr` sequence 0, 4, 8; IF/ID = (4,0x11,1), (8,0x22,1), (12,0x33,1) on consecutive cycles.
- Ack delayed 3 cycles at addr 0: `imem_addr` stable at 0 throughout; `if_id_valid`=0 for 3 cycles, then (4, rdata, 1).
- `freeze`=1 for 2 cycles, ack arriving in the first: IF/ID unchanged and `imem_req`=0 in STALL; on release IF/ID = buffered (pc+4, instr, 1); next `imem_addr` = pc+4.
- `branch_taken`, `branch_addr`=0x100, with a request at 0x8 outstanding (ack 2 cycles later): IF/ID flushed; `imem_addr` stays 0x8 until ack; data discarded; next `imem_addr`=0x100; first valid IF/ID pc = 0x104.
- `branch_taken` and `freeze` high together while in STALL: buffer dropped, `if_id_valid`=0, `imem_addr`=`branch_addr` next cycle.
- `pc`=0xFFFFFFFC with an ack: `if_id_pc`=0 and the next `imem_addr`=0. Then `rst` pulsed low mid-request: all outputs 0 immediately (asynchronously); fetch restarts at 0.
